// File: rtl/carry_prefix_pipe_pkg.sv
// Shared ALU constants for the prefix adder and the pg stage.
// S1_LEVELS is the number of prefix levels evaluated before the S2 register.
package carry_prefix_pipe_pkg;
  localparam int ALU_WIDTH     = 17;
  localparam int PREFIX_LEVELS = 5;
  localparam int S1_LEVELS     = 3;
endpackage

// File: rtl/carry_prefix_pipe_pg_dot.sv
// Kogge-Stone prefix operator: (G,P)hi o (G,P)lo.
module pg_dot (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g_out,
  output logic p_out
);
  assign g_out = g_hi | (p_hi & g_lo);
  assign p_out = p_hi & p_lo;
endmodule

// File: rtl/carry_prefix_pipe.sv
// Three-stage pipelined Kogge-Stone carry network with valid/ready handshake.
// Levels with spans 1,2,4 sit between S1 and S2; spans 8,16 sit between S2 and S3.
module carry_prefix_pipe
  import carry_prefix_pipe_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_p,
  input  logic [WIDTH-1:0] in_g,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);
  logic             r_v1, r_v2, r_v3;
  logic [WIDTH-1:0] r1_p, r1_g;
  logic             r1_cin;
  logic [WIDTH-1:0] r2_g, r2_p_grp, r2_p;
  logic             r2_cin;
  logic [WIDTH-1:0] r3_sum;
  logic             r3_cout, r3_ovf;

  logic             w_ld1, w_ld2, w_ld3;
  logic [WIDTH-1:0] w_g0;
  logic [WIDTH-1:0] w_g_s1, w_p_s1, w_g_s2;
  logic             w_unused_p;

  assign w_ld3    = !r_v3 || out_ready;
  assign w_ld2    = !r_v2 || w_ld3;
  assign w_ld1    = !r_v1 || w_ld2;
  assign in_ready = w_ld1;

  // Carry-in folded in as a generate below bit 0.
  assign w_g0 = {r1_g[WIDTH-1:1], r1_g[0] | (r1_p[0] & r1_cin)};

  genvar lv, i;
  for (lv = 0; lv < S1_LEVELS; lv++) begin : g_s1
    localparam int SPAN = 1 << lv;
    logic [WIDTH-1:0] w_g_in, w_p_in, w_g, w_p;
    if (lv == 0) begin : g_first
      assign w_g_in = w_g0;
      assign w_p_in = r1_p;
    end else begin : g_next
      assign w_g_in = g_s1[lv-1].w_g;
      assign w_p_in = g_s1[lv-1].w_p;
    end
    for (i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= SPAN) begin : g_dot
        pg_dot u_dot (
          .g_hi (w_g_in[i]),      .p_hi (w_p_in[i]),
          .g_lo (w_g_in[i-SPAN]), .p_lo (w_p_in[i-SPAN]),
          .g_out(w_g[i]),         .p_out(w_p[i])
        );
      end else begin : g_pass
        assign w_g[i] = w_g_in[i];
        assign w_p[i] = w_p_in[i];
      end
    end
  end
  assign w_g_s1 = g_s1[S1_LEVELS-1].w_g;
  assign w_p_s1 = g_s1[S1_LEVELS-1].w_p;

  for (lv = 0; lv < PREFIX_LEVELS - S1_LEVELS; lv++) begin : g_s2
    localparam int SPAN = 1 << (S1_LEVELS + lv);
    logic [WIDTH-1:0] w_g_in, w_p_in, w_g, w_p;
    if (lv == 0) begin : g_first
      assign w_g_in = r2_g;
      assign w_p_in = r2_p_grp;
    end else begin : g_next
      assign w_g_in = g_s2[lv-1].w_g;
      assign w_p_in = g_s2[lv-1].w_p;
    end
    for (i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= SPAN) begin : g_dot
        pg_dot u_dot (
          .g_hi (w_g_in[i]),      .p_hi (w_p_in[i]),
          .g_lo (w_g_in[i-SPAN]), .p_lo (w_p_in[i-SPAN]),
          .g_out(w_g[i]),         .p_out(w_p[i])
        );
      end else begin : g_pass
        assign w_g[i] = w_g_in[i];
        assign w_p[i] = w_p_in[i];
      end
    end
  end
  assign w_g_s2 = g_s2[PREFIX_LEVELS-S1_LEVELS-1].w_g;
  // Group propagate of the last level has no consumer.
  assign w_unused_p = ^g_s2[PREFIX_LEVELS-S1_LEVELS-1].w_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_v3     <= 1'b0;
      r1_p     <= '0;
      r1_g     <= '0;
      r1_cin   <= 1'b0;
      r2_g     <= '0;
      r2_p_grp <= '0;
      r2_p     <= '0;
      r2_cin   <= 1'b0;
      r3_sum   <= '0;
      r3_cout  <= 1'b0;
      r3_ovf   <= 1'b0;
    end else begin
      if (w_ld1) begin
        r_v1   <= in_valid;
        r1_p   <= in_p;
        r1_g   <= in_g;
        r1_cin <= in_cin;
      end
      if (w_ld2) begin
        r_v2     <= r_v1;
        r2_g     <= w_g_s1;
        r2_p_grp <= w_p_s1;
        r2_p     <= r1_p;
        r2_cin   <= r1_cin;
      end
      // c(i+1) = G[i], c0 = cin
      if (w_ld3) begin
        r_v3    <= r_v2;
        r3_sum  <= r2_p ^ {w_g_s2[WIDTH-2:0], r2_cin};
        r3_cout <= w_g_s2[WIDTH-1];
        r3_ovf  <= w_g_s2[WIDTH-1] ^ w_g_s2[WIDTH-2];
      end
    end
  end

  assign out_valid = r_v3;
  assign out_sum   = r3_sum;
  assign out_cout  = r3_cout;
  assign out_ovf   = r3_ovf;
endmodule

// File: doc/carry_prefix_pipe.md
# carry_prefix_pipe

Pipelined Kogge-Stone carry network for the 17-bit ALU adder. It sits directly downstream of the propagate/generate stage, consuming per-bit `p`/`g` plus a carry-in, and produces the sum, carry-out and signed overflow. Three register stages with a valid/ready handshake give full throughput (one operation per cycle) and allow back-pressure from the ALU result path.

## Interface
- `WIDTH`, 17: operand width in bits. Only 17 is verified.
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `in_valid`  in  1: `in_p`/`in_g`/`in_cin` carry a valid operation.
- `in_ready`  out  1: block accepts the operation this cycle.
- `in_p`  in  17: propagate bits (a ^ b).
- `in_g`  in  17: generate bits (a & b).
- `in_cin`  in  1: adder carry-in.
- `out_valid`  out  1: result fields valid.
- `out_ready`  in  1: consumer takes the result this cycle.
- `out_sum`  out  17: p ^ carries.
- `out_cout`  out  1: carry out of bit 16 (c17).
- `out_ovf`  out  1: signed overflow, c17 ^ c16.

## Operation
- Carry definition: c0 = cin; c(i+1) = g(i) | p(i)&c(i). The carry-in is folded in as a generate below bit 0: G0' = g0 | p0&cin.
- Prefix operator (dot): (G,P)hi ∘ (G,P)lo = (Ghi | Phi&Glo, Phi&Plo).
- Five levels with spans 1, 2, 4, 8 and 16. Position i uses the dot operator with position i−span when i ≥ span; otherwise the pair passes through unchanged.
- Stage S1 registers `in_p`, `in_g` and `in_cin` on acceptance.
- Between S1 and S2: levels 1–3 (spans 1, 2, 4). S2 registers the group G[16:0] and P[16:0] plus the original p[16:0].
- Between S2 and S3: levels 4–5 (spans 8, 16). This gives c(i+1) = G[i] and c0 = cin. S3 registers `out_sum`, `out_cout` and `out_ovf`.
- Each stage has a valid bit v1/v2/v3. `out_valid` = v3.
- Stall rule, applied per stage k: stage k loads when its own valid bit is clear or stage k+1 loads. Stage 3 loads when `!v3 || out_ready`.
- `in_ready` = stage-1 load enable. It is combinational from `out_ready`; no registered skid buffer.
- A stage that loads while its upstream valid bit is 0 clears its valid bit. Data registers of invalid stages may hold stale values.
- All arithmetic is unsigned bitwise. There is no width growth beyond `out_cout`.

## Timing
- Reset (async assert, values hold while `rst` is high): v1 = v2 = v3 = 0, `out_sum` = 0, `out_cout` = 0, `out_ovf` = 0, `in_ready` = 1.
- Reset is released synchronously to `clk` by the system.
- Latency: an operation accepted at edge t (in_valid & in_ready) appears with `out_valid` = 1 after edge t+2, i.e. 3 cycles including the acceptance cycle.
- Throughput: 1 operation per cycle while `out_ready` is held high.
- Back-pressure: while `out_valid` & !`out_ready`, the outputs hold stable. The pipeline fills to at most 3 operations, then `in_ready` drops in the same cycle.
- Simultaneous events: if `out_ready` rises while the pipeline is full, `in_ready` is 1 in that same cycle and all stages shift together. No bubble and no loss.
- Ordering: results leave strictly in acceptance order.
- Reset mid-operation: all in-flight operations are discarded. No `out_valid` pulse follows reset release until a new acceptance plus 3 cycles.
- Critical path: at most 3 dot levels between registers.

## Structure
- Shared ALU header/package holds `ALU_WIDTH` = 17 and `PREFIX_LEVELS` = 5. `gen_pg` uses the same width constant.
- Sub-module `pg_dot` is the combinational prefix operator:
  - inputs: g_hi, p_hi, g_lo, p_lo
  - outputs: g_out, p_out
  - instantiated per bit per level by generate loops.
- Stage control (valid bits, load enables) stays in `carry_prefix_pipe`.

## Test plan
- p=0x0FFFE, g=0x00001, cin=0 (a=0x0FFFF, b=1) -> sum=0x10000, cout=0, ovf=1, `out_valid` 3 cycles after acceptance.
- p=0x1FFFE, g=0x00001, cin=0 (a=0x1FFFF, b=1) -> sum=0x00000, cout=1, ovf=0. Then p=0x1FFFF, g=0, cin=1 -> sum=0, cout=1, ovf=0 (full-length carry chain).
- Back-to-back stream of 10 random operations with `out_ready`=1 -> 10 consecutive valid results, in order, each matching a reference a+b+cin.
- Hold `out_ready`=0 and drive 5 operations -> exactly 3 accepted, `in_ready`=0 after the third. Raise `out_ready` -> results emerge in order, no loss or duplication.
- Assert `rst` mid-cycle with 2 operations in flight -> `out_valid`=0 and sum/cout/ovf=0 immediately. After release, no result until a new acceptance.
- Toggle `out_ready` randomly against random `in_valid` for 1000 cycles -> scoreboard matches every result, and outputs stay stable whenever `out_valid` & !`out_ready`.
